// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle between NUM_REQ requesters, the round-robin arbiter and its single downstream consumer.
// The slave modport is the arbiter side; master is the surrounding environment.
interface stream_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;

  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_last;
  logic [SRC_W-1:0]              out_src;

  // Observation of the internal arbitration state.
  logic [SRC_W-1:0]              dbg_rr_ptr;
  logic                          dbg_locked;

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src,
    output dbg_rr_ptr, dbg_locked
  );

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src,
    input  dbg_rr_ptr, dbg_locked
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter feeding one registered output stage from NUM_REQ streams.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant on one requester until its last beat.
module stream_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst,
  stream_rr_arbiter_if.slave  bus
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [SRC_W:0]   NREQ_EXT = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ-1);

  // Handshake: a beat moves when valid & ready are both high at a rising edge;
  // a source holds valid and its payload stable until that happens, and ready
  // never depends on the payload or last flag.

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic [SRC_W-1:0]      out_src_q;
  logic [SRC_W-1:0]      rr_ptr;

  logic [DATA_WIDTH-1:0] req_beat [NUM_REQ];
  logic [SRC_W:0]        cand;
  logic [SRC_W-1:0]      rr_idx;
  logic                  any_valid;
  logic [SRC_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  gnt_last;
  logic                  accept;
  logic                  xfer;
  logic                  ptr_adv;
  logic [NUM_REQ-1:0]    ready_vec;
  logic [SRC_W-1:0]      ptr_nxt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_beat[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Walk from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    cand      = '0;
    rr_idx    = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (cand >= NREQ_EXT) cand = cand - NREQ_EXT;
      if (bus.req_valid[cand[SRC_W-1:0]]) begin
        any_valid = 1'b1;
        rr_idx    = cand[SRC_W-1:0];
      end
    end
  end

  assign accept   = ~out_valid_q | bus.out_ready;
  assign gnt_last = bus.req_last[gnt_idx];
  assign xfer     = gnt_any & accept & ~rst;
  assign ptr_nxt  = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    ready_vec          = '0;
    ready_vec[gnt_idx] = xfer;
  end

`ifdef STREAM_ARB_PKT_LOCK_EN
  typedef enum logic {LK_OPEN, LK_HELD} lock_state_e;

  lock_state_e      lock_state, lock_state_nxt;
  logic [SRC_W-1:0] lock_id, lock_id_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state <= LK_OPEN;
      lock_id    <= '0;
    end else begin
      lock_state <= lock_state_nxt;
      lock_id    <= lock_id_nxt;
    end
  end

  always_comb begin
    lock_state_nxt = lock_state;
    lock_id_nxt    = lock_id;
    case (lock_state)
      LK_OPEN: if (xfer && !gnt_last) begin
        lock_state_nxt = LK_HELD;
        lock_id_nxt    = gnt_idx;
      end
      LK_HELD: if (xfer && gnt_last) lock_state_nxt = LK_OPEN;
      default: lock_state_nxt = LK_OPEN;
    endcase
  end

  // A held lock pins the grant even while the owner idles, leaving bubbles.
  assign gnt_idx        = (lock_state == LK_HELD) ? lock_id : rr_idx;
  assign gnt_any        = (lock_state == LK_HELD) ? bus.req_valid[lock_id] : any_valid;
  assign ptr_adv        = xfer & gnt_last;
  assign bus.dbg_locked = (lock_state == LK_HELD);
`else
  assign gnt_idx        = rr_idx;
  assign gnt_any        = any_valid;
  assign ptr_adv        = xfer;
  assign bus.dbg_locked = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      rr_ptr      <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= req_beat[gnt_idx];
        out_last_q  <= gnt_last;
        out_src_q   <= gnt_idx;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (ptr_adv) rr_ptr <= ptr_nxt;
    end
  end

  assign bus.req_ready  = ready_vec;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_src    = out_src_q;
  assign bus.dbg_rr_ptr = rr_ptr;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: reset, rotation, backpressure, sparse wrap, packet behaviour.
// Packet expectations follow STREAM_ARB_PKT_LOCK_EN when it is defined.
module tb_stream_rr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] data_r [NR];
  logic [DW-1:0] exp_q [$];

  stream_rr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  stream_rr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef STREAM_ARB_PKT_LOCK_EN
  logic [NR-1:0] pk_rdy  [7] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
  logic          pk_v    [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0]    pk_src  [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
  logic [DW-1:0] pk_data [7] = '{32'hB1, 32'hB1, 32'hB1, 32'hB2, 32'hB3, 32'hA0, 32'hA0};
  logic          pk_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic          pk_lock [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
  logic [NR-1:0] pk_rdy  [7] = '{4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
  logic          pk_v    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0]    pk_src  [7] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
  logic [DW-1:0] pk_data [7] = '{32'hB1, 32'hA0, 32'hA0, 32'hB2, 32'hA0, 32'hB3, 32'hA0};
  logic          pk_last [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic          pk_lock [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: apply inputs, check ready mid-cycle, then move 1 ns past the edge
  task automatic step(input logic [NR-1:0] vmask, input logic ordy,
                      input logic [NR-1:0] exp_rdy, input string tag);
    bus.req_valid = vmask;
    bus.out_ready = ordy;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = data_r[i];
    #4;
    check_eq({tag, ".ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] src,
                           input logic [DW-1:0] d, input logic last);
    check_eq({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
    if (v) begin
      check_eq({tag, ".src"},  64'(bus.out_src),  64'(src));
      check_eq({tag, ".data"}, 64'(bus.out_data), 64'(d));
      check_eq({tag, ".last"}, 64'(bus.out_last), 64'(last));
    end
  endtask

  initial begin
    logic [NR-1:0] er;
    logic [NR-1:0] mask;
    int            pk;

    for (int i = 0; i < NR; i++) data_r[i] = 32'hA0 + 32'(i);
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;

    // reset held two cycles with every requester valid
    for (int c = 0; c < 2; c++) begin
      step(4'b1111, 1'b1, 4'b0000, "rst");
      check_eq("rst.valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst.data",  64'(bus.out_data),  64'd0);
      check_eq("rst.src",   64'(bus.out_src),   64'd0);
      check_eq("rst.ptr",   64'(bus.dbg_rr_ptr), 64'd0);
    end
    rst = 1'b0;

    // rotation: all valid, grants 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) exp_q.push_back(32'hA0 + 32'(k % NR));
    for (int k = 0; k < 8; k++) begin
      er = 4'(1 << (k % NR));
      step(4'b1111, 1'b1, er, "rot");
      check_out("rot", 1'b1, 2'(k % NR), exp_q.pop_front(), 1'b1);
    end

    // backpressure: 0x55 from requester 2 held through a 3-cycle stall
    data_r[2] = 32'h55;
    step(4'b0100, 1'b1, 4'b0100, "bp_send");
    check_out("bp_send", 1'b1, 2'd2, 32'h55, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(4'b1010, 1'b0, 4'b0000, "bp_stall");
      check_out("bp_stall", 1'b1, 2'd2, 32'h55, 1'b1);
    end
    step(4'b1010, 1'b1, 4'b1000, "bp_release");
    check_out("bp_release", 1'b1, 2'd3, 32'hA3, 1'b1);
    data_r[2] = 32'hA2;

    // sparse and wrap: only 3 and 0 valid, starting from rr_ptr=3
    step(4'b0100, 1'b1, 4'b0100, "sp_setup");
    check_out("sp_setup", 1'b1, 2'd2, 32'hA2, 1'b1);
    check_eq("sp_setup.ptr", 64'(bus.dbg_rr_ptr), 64'd3);
    step(4'b1001, 1'b1, 4'b1000, "sp_g3a");
    check_out("sp_g3a", 1'b1, 2'd3, 32'hA3, 1'b1);
    step(4'b1001, 1'b1, 4'b0001, "sp_g0");
    check_out("sp_g0", 1'b1, 2'd0, 32'hA0, 1'b1);
    step(4'b1001, 1'b1, 4'b1000, "sp_g3b");
    check_out("sp_g3b", 1'b1, 2'd3, 32'hA3, 1'b1);

    // put rr_ptr at 1 so requester 1 opens the packet test
    step(4'b0001, 1'b1, 4'b0001, "pk_setup");
    check_out("pk_setup", 1'b1, 2'd0, 32'hA0, 1'b1);
    check_eq("pk_setup.ptr", 64'(bus.dbg_rr_ptr), 64'd1);

    // requester 1: 3-beat packet with a 2-cycle gap after beat 1; requester 0 always valid
    pk = 0;
    for (int c = 0; c < 7; c++) begin
      mask         = {2'b00, (pk < 3) && !(c == 1 || c == 2), 1'b1};
      data_r[1]    = 32'hB1 + 32'(pk);
      bus.req_last = (pk == 2) ? 4'b1111 : 4'b1101;
      step(mask, 1'b1, pk_rdy[c], "pkt");
      check_out("pkt", pk_v[c], pk_src[c], pk_data[c], pk_last[c]);
      check_eq("pkt.locked", 64'(bus.dbg_locked), 64'(pk_lock[c]));
      if (pk_rdy[c][1]) pk++;
    end
    bus.req_last = '1;

    // drain: output empties, payload and source hold
    step(4'b0000, 1'b1, 4'b0000, "drain");
    check_eq("drain.valid", 64'(bus.out_valid), 64'd0);
    check_eq("drain.data",  64'(bus.out_data),  64'hA0);
    check_eq("drain.src",   64'(bus.out_src),   64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
